valid_ready_width_upsizer: RTL and testbench

Downstream packing stage for the valid-ready LIFO read port. It accumulates RATIO consecutive WIDTH-bit beats into one WIDTH*RATIO-bit word with a per-lane keep mask. A flush request emits a partially filled word. The output is fully registered, which also cuts the LIFO's combinational read path.

---
 rtl/valid_ready_width_upsizer.sv | 96 +++++++++
 tb/tb_valid_ready_width_upsizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/valid_ready_width_upsizer.sv
// Packs RATIO narrow valid-ready beats into one registered wide word with a lane keep mask.
// Optional macro VALID_READY_WIDTH_UPSIZER_REVERSE_LANES_EN places the first beat in the MSB lane.
module valid_ready_width_upsizer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       write_valid,
    output logic                       write_ready,
    input  logic                       flush,
    output logic [WIDTH*RATIO-1:0]     read_data,
    output logic [RATIO-1:0]           read_keep,
    output logic                       read_valid,
    input  logic                       read_ready,
    output logic [$clog2(RATIO)-1:0]   lane_count
);

    localparam int CW = $clog2(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [(RATIO-1)*WIDTH-1:0] acc;
    logic [RATIO*WIDTH-1:0]     acc_ext;
    logic                       slot_free;
    logic                       accept;
    logic                       completing;
    logic                       do_flush;
    logic                       load;
    logic [CW:0]                held;
    logic [CW:0]                n_after;
    logic [RATIO*WIDTH-1:0]     word;
    logic [RATIO-1:0]           keep;

    // Output lane for the k-th beat of a word; the accumulator itself is always kept in arrival order.
    function automatic int unsigned lane_pos(input int unsigned k);
`ifdef VALID_READY_WIDTH_UPSIZER_REVERSE_LANES_EN
        return RATIO - 1 - k;
`else
        return k;
`endif
    endfunction

    assign acc_ext     = {{WIDTH{1'b0}}, acc};
    assign slot_free   = ~read_valid | read_ready;
    assign write_ready = (lane_count != LAST) | slot_free;
    assign accept      = write_valid & write_ready;
    assign completing  = accept & (lane_count == LAST);
    assign held        = {1'b0, lane_count};
    assign n_after     = held + (CW+1)'(accept);
    // A completing beat already emits the full word, so flush folds into the same load.
    assign do_flush    = flush & slot_free & (n_after != '0);
    assign load        = completing | do_flush;

    always_comb begin
        word = '0;
        keep = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if ((CW+1)'(i) < held)
                word[lane_pos(i)*WIDTH +: WIDTH] = acc_ext[i*WIDTH +: WIDTH];
            else if (accept && ((CW+1)'(i) == held))
                word[lane_pos(i)*WIDTH +: WIDTH] = write_data;
            keep[lane_pos(i)] = ((CW+1)'(i) < n_after);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lane_count <= '0;
            acc        <= '0;
            read_data  <= '0;
            read_keep  <= '0;
            read_valid <= 1'b0;
        end else begin
            if (load) begin
                read_data  <= word;
                read_keep  <= keep;
                read_valid <= 1'b1;
            end else if (read_ready) begin
                read_valid <= 1'b0;
            end

            if (load) begin
                lane_count <= '0;
                acc        <= '0;
            end else if (accept) begin
                for (int unsigned i = 0; i < RATIO - 1; i++) begin
                    if (lane_count == CW'(i))
                        acc[i*WIDTH +: WIDTH] <= write_data;
                end
                lane_count <= lane_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_valid_ready_width_upsizer.sv
// Randomised bench for valid_ready_width_upsizer against a queue-based packing model.
// Honours VALID_READY_WIDTH_UPSIZER_REVERSE_LANES_EN for expected lane order.
module tb_valid_ready_width_upsizer;

    localparam int W = 8;
    localparam int R = 4;
`ifdef VALID_READY_WIDTH_UPSIZER_REVERSE_LANES_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic [W-1:0]   write_data;
    logic           write_valid;
    logic           write_ready;
    logic           flush;
    logic [W*R-1:0] read_data;
    logic [R-1:0]   read_keep;
    logic           read_valid;
    logic           read_ready;
    logic [1:0]     lane_count;

    valid_ready_width_upsizer #(.WIDTH(W), .RATIO(R)) dut (
        .clock       (clock),
        .reset       (reset),
        .write_data  (write_data),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .flush       (flush),
        .read_data   (read_data),
        .read_keep   (read_keep),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .lane_count  (lane_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: beats collected so far plus the output register contents.
    logic [W-1:0]   beats[$];
    logic           m_valid = 1'b0;
    logic [W*R-1:0] m_data  = '0;
    logic [R-1:0]   m_keep  = '0;
    logic [W*R-1:0] got_d[$];
    logic [R-1:0]   got_k[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lit_d(input logic [31:0] lsb);
        return REV ? {lsb[7:0], lsb[15:8], lsb[23:16], lsb[31:24]} : lsb;
    endfunction

    function automatic logic [3:0] lit_k(input logic [3:0] lsb);
        return REV ? {lsb[0], lsb[1], lsb[2], lsb[3]} : lsb;
    endfunction

    task automatic emit();
        m_data = '0;
        m_keep = '0;
        foreach (beats[i]) begin
            int pos;
            pos = REV ? (R - 1 - i) : i;
            m_data[pos*W +: W] = beats[i];
            m_keep[pos] = 1'b1;
        end
        beats.delete();
        m_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clock);
        if (reset) begin
            beats.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_keep  = '0;
        end else begin
            bit sf;
            bit wr;
            sf = !m_valid || read_ready;
            wr = (beats.size() != R - 1) || sf;
            if (m_valid && read_ready) begin
                got_d.push_back(m_data);
                got_k.push_back(m_keep);
            end
            if (write_valid && wr) beats.push_back(write_data);
            if (beats.size() == R) emit();
            else if (flush && sf && beats.size() > 0) emit();
            else if (read_ready) m_valid = 1'b0;
        end
    end

    initial forever begin
        @(negedge clock);
        #2;
        if (chk_en) begin
            chk("read_valid", 64'(read_valid), 64'(m_valid));
            chk("lane_count", 64'(lane_count), 64'(beats.size()));
            chk("write_ready", 64'(write_ready),
                64'((beats.size() != R - 1) || !m_valid || read_ready));
            if (m_valid) begin
                chk("read_data", 64'(read_data), 64'(m_data));
                chk("read_keep", 64'(read_keep), 64'(m_keep));
            end
        end
    end

    task automatic push(input logic [W-1:0] b, input bit rnd_rr);
        bit ok;
        ok = 1'b0;
        write_data  = b;
        write_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (rnd_rr) read_ready = 1'($urandom_range(0, 1));
            #1;
            if (write_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk("push_accepted", 64'(ok), 64'(1));
        @(negedge clock);
        write_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        write_valid = 1'b0;
        flush = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int c0;
        reset = 1'b1; write_valid = 1'b0; write_data = '0; flush = 1'b0; read_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_en = 1'b1;
        #1;
        chk("rst_valid", 64'(read_valid), 64'(0));
        chk("rst_lane", 64'(lane_count), 64'(0));
        chk("rst_keep", 64'(read_keep), 64'(0));
        chk("rst_data", 64'(read_data), 64'(0));
        reset = 1'b0;

        // Full word, read_ready high
        read_ready = 1'b1;
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        #1;
        chk("t1_data", 64'(read_data), 64'(lit_d(32'h44332211)));
        chk("t1_keep", 64'(read_keep), 64'(lit_k(4'b1111)));
        chk("t1_valid", 64'(read_valid), 64'(1));
        chk("t1_lane", 64'(lane_count), 64'(0));
        @(negedge clock); #1;
        chk("t1_drain", 64'(read_valid), 64'(0));

        // Backpressure with a pending word
        read_ready = 1'b0;
        push(8'hA1, 0); push(8'hA2, 0); push(8'hA3, 0); push(8'hA4, 0);
        push(8'h55, 0); push(8'h66, 0); push(8'h77, 0);
        write_data = 8'h88; write_valid = 1'b1;
        repeat (3) begin
            #1;
            chk("t2_stall_wr", 64'(write_ready), 64'(0));
            chk("t2_hold_data", 64'(read_data), 64'(lit_d(32'hA4A3A2A1)));
            chk("t2_hold_valid", 64'(read_valid), 64'(1));
            @(negedge clock);
        end
        read_ready = 1'b1;
        #1;
        chk("t2_release_wr", 64'(write_ready), 64'(1));
        @(negedge clock);
        write_valid = 1'b0;
        #1;
        chk("t2_data", 64'(read_data), 64'(lit_d(32'h88776655)));
        chk("t2_valid", 64'(read_valid), 64'(1));
        idle(2);

        // Partial flush
        push(8'hAA, 0); push(8'hBB, 0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        #1;
        chk("t3_data", 64'(read_data), 64'(lit_d(32'h0000BBAA)));
        chk("t3_keep", 64'(read_keep), 64'(lit_k(4'b0011)));
        chk("t3_lane", 64'(lane_count), 64'(0));
        idle(2);

        // Empty flush, then flush on completing beat
        flush = 1'b1;
        repeat (3) begin
            @(negedge clock); #1;
            chk("t4_no_empty", 64'(read_valid), 64'(0));
        end
        flush = 1'b0;
        c0 = got_d.size();
        push(8'hC1, 0); push(8'hC2, 0); push(8'hC3, 0);
        flush = 1'b1;
        push(8'hC4, 0);
        flush = 1'b0;
        idle(3);
        chk("t4_one_word", 64'(got_d.size() - c0), 64'(1));
        chk("t4_data", 64'(got_d[c0]), 64'(lit_d(32'hC4C3C2C1)));
        chk("t4_keep", 64'(got_k[c0]), 64'(lit_k(4'b1111)));

        // Streaming with random backpressure
        c0 = got_d.size();
        for (int b = 1; b <= 12; b++) push(8'(b), 1);
        read_ready = 1'b1;
        idle(4);
        chk("t5_count", 64'(got_d.size() - c0), 64'(3));
        chk("t5_w0", 64'(got_d[c0]), 64'(lit_d(32'h04030201)));
        chk("t5_w1", 64'(got_d[c0+1]), 64'(lit_d(32'h08070605)));
        chk("t5_w2", 64'(got_d[c0+2]), 64'(lit_d(32'h0C0B0A09)));

        // Reset mid-word with an output pending
        read_ready = 1'b0;
        push(8'hE1, 0); push(8'hE2, 0); push(8'hE3, 0); push(8'hE4, 0);
        push(8'hF1, 0); push(8'hF2, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("t6_valid", 64'(read_valid), 64'(0));
        chk("t6_lane", 64'(lane_count), 64'(0));
        chk("t6_keep", 64'(read_keep), 64'(0));
        read_ready = 1'b1;
        c0 = got_d.size();
        push(8'hD1, 0); push(8'hD2, 0); push(8'hD3, 0); push(8'hD4, 0);
        idle(2);
        chk("t6_count", 64'(got_d.size() - c0), 64'(1));
        chk("t6_word", 64'(got_d[c0]), 64'(lit_d(32'hD4D3D2D1)));

        // Free-running random traffic
        for (int n = 0; n < 400; n++) begin
            write_valid = 1'($urandom_range(0, 1));
            write_data  = 8'($urandom);
            flush       = ($urandom_range(0, 3) == 0);
            read_ready  = 1'($urandom_range(0, 2) != 0);
            @(negedge clock);
        end
        write_valid = 1'b0;
        read_ready = 1'b1;
        flush = 1'b1;
        repeat (3) @(negedge clock);
        idle(3);
        chk("final_lane", 64'(lane_count), 64'(0));
        chk("final_valid", 64'(read_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1);
    end

endmodule
